tone_sequencer: RTL and testbench

Programmable note sequencer that sits directly upstream of the audio clock divider. It stores a short list of (divisor, duration) entries and plays them in order. For each entry it presents the divisor and holds it for the programmed number of milliseconds, then optionally loops. `tone_en` is intended to drive the divider's active-low reset, so the divider is held cleared during rests, gaps and idle.

---
 rtl/tone_sequencer_if.sv | 32 +++
 rtl/tone_sequencer.sv | 148 ++++++++++++++
 tb/tb_tone_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_if.sv
// Bus bundle for tone_sequencer: entry writes, playback control and the
// divisor/status outputs. The master drives commands and the slave drives status.
interface tone_sequencer_if #(
    parameter int DEPTH = 8
) ();
    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;

    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [31:0]   wr_divisor;
    logic [15:0]   wr_dur_ms;
    logic [LW-1:0] length;
    logic          loop;
    logic          start;
    logic          stop;
    logic [31:0]   divisor;
    logic          tone_en;
    logic          busy;
    logic          done;
    logic [IW-1:0] index;

    modport master (
        output wr_en, wr_addr, wr_divisor, wr_dur_ms, length, loop, start, stop,
        input  divisor, tone_en, busy, done, index
    );

    modport slave (
        input  wr_en, wr_addr, wr_divisor, wr_dur_ms, length, loop, start, stop,
        output divisor, tone_en, busy, done, index
    );
endinterface

// File: rtl/tone_sequencer.sv
// Note sequencer feeding the audio clock divider. It plays stored
// (divisor, ms) entries in order, optionally looping. tone_en gates the divider.
module tone_sequencer #(
    parameter int DEPTH        = 8,
    parameter int TICKS_PER_MS = 50000
) (
    input  logic             clk,
    input  logic             reset,
    tone_sequencer_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;
    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

    state_t        state_q, state_d;
    logic [47:0]   mem_q [DEPTH];
    logic [47:0]   mem_d [DEPTH];
    logic [31:0]   divisor_q, divisor_d;
    logic          tone_en_q, tone_en_d;
    logic          done_q, done_d;
    logic [IW-1:0] index_q, index_d;
    logic [LW-1:0] len_q, len_d;
    logic          loop_q, loop_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ms_q, ms_d;

    logic          busy;
    logic [LW-1:0] len_clamped;
    logic [47:0]   entry;
    logic [15:0]   dur_eff;
    logic          ms_tick;
    logic          entry_end;
    logic          last_entry;

    always_comb begin
        busy        = (state_q != S_IDLE);
        len_clamped = (bus.length > DEPTH_L) ? DEPTH_L : bus.length;
        entry       = mem_q[index_q];
        dur_eff     = (entry[15:0] == 16'd0) ? 16'd1 : entry[15:0];
        ms_tick     = (presc_q == PRESC_MAX);
        entry_end   = (state_q == S_PLAY) && ms_tick && ((ms_q + 16'd1) == dur_eff);
        last_entry  = ({1'b0, index_q} == (len_q - LW'(1)));

        // The array only accepts writes while idle so a playing entry never changes underneath.
        mem_d = mem_q;
        if (bus.wr_en && !busy) begin
            mem_d[bus.wr_addr] = {bus.wr_divisor, bus.wr_dur_ms};
        end
    end

    always_comb begin
        state_d   = state_q;
        divisor_d = divisor_q;
        index_d   = index_q;
        len_d     = len_q;
        loop_d    = loop_q;
        presc_d   = presc_q;
        ms_d      = ms_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && (len_clamped != '0)) begin
                    state_d = S_LOAD;
                    index_d = '0;
                    len_d   = len_clamped;
                    loop_d  = bus.loop;
                end
            end
            S_LOAD: begin
                state_d   = S_PLAY;
                divisor_d = entry[47:16];
                presc_d   = '0;
                ms_d      = '0;
            end
            S_PLAY: begin
                presc_d = ms_tick ? '0 : presc_q + PW'(1);
                if (ms_tick) begin
                    ms_d = ms_q + 16'd1;
                end
                if (entry_end) begin
                    if (!last_entry) begin
                        state_d = S_LOAD;
                        index_d = index_q + IW'(1);
                    end else if (loop_q) begin
                        state_d = S_LOAD;
                        index_d = '0;
                    end else begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        divisor_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stop overrides a simultaneous start or end of entry.
        if (bus.stop) begin
            state_d   = S_IDLE;
            divisor_d = '0;
            index_d   = '0;
            done_d    = 1'b0;
        end

        tone_en_d = (state_d == S_PLAY) && (divisor_d != 32'd0);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            divisor_q <= '0;
            tone_en_q <= 1'b0;
            done_q    <= 1'b0;
            index_q   <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            presc_q   <= '0;
            ms_q      <= '0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            tone_en_q <= tone_en_d;
            done_q    <= done_d;
            index_q   <= index_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            presc_q   <= presc_d;
            ms_q      <= ms_d;
        end
    end

    assign bus.divisor = divisor_q;
    assign bus.tone_en = tone_en_q;
    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.index   = index_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with DEPTH=8 and TICKS_PER_MS=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tone_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    logic [37:0] obs, exp;
    logic        eb, et, ed;
    logic [2:0]  ei;
    logic [31:0] edv;

    tone_sequencer_if #(.DEPTH(8)) dif ();

    tone_sequencer #(.DEPTH(8), .TICKS_PER_MS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic write_entry(input int addr, input int div, input int dur);
        dif.wr_en      = 1'b1;
        dif.wr_addr    = 3'(addr);
        dif.wr_divisor = 32'(div);
        dif.wr_dur_ms  = 16'(dur);
        @(negedge clk);
        dif.wr_en      = 1'b0;
    endtask

    task automatic start_seq(input int len, input logic lp);
        dif.start  = 1'b1;
        dif.length = 4'(len);
        dif.loop   = lp;
        @(negedge clk);
        dif.start  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        obs = {dif.busy, dif.tone_en, dif.done, dif.index, dif.divisor};
        exp = '0;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_hold got %h expected %h", obs, exp);
        end
        reset = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            obs = {dif.busy, dif.tone_en, dif.done, dif.index, dif.divisor};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_idle cyc%0d got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_basic();
        write_entry(0, 1000, 2);
        write_entry(1, 0, 1);
        write_entry(2, 500, 3);
        start_seq(3, 1'b0);
        for (int c = 1; c <= 29; c++) begin
            if (c > 1) @(negedge clk);
            eb  = (c <= 27);
            et  = (c >= 2 && c <= 9) || (c >= 16 && c <= 27);
            ed  = (c == 28);
            ei  = (c <= 9) ? 3'd0 : (c <= 14) ? 3'd1 : 3'd2;
            edv = (c == 1) ? 32'd0 : (c <= 10) ? 32'd1000 : (c <= 15) ? 32'd0 :
                  (c <= 27) ? 32'd500 : 32'd0;
            obs = {dif.busy, dif.tone_en, dif.done, dif.index, dif.divisor};
            if (c >= 28) begin
                obs[34:32] = 3'd0;
                ei = 3'd0;
            end
            exp = {eb, et, ed, ei, edv};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL basic_play cyc%0d got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_loop_stop();
        start_seq(3, 1'b1);
        for (int c = 1; c <= 32; c++) begin
            if (c > 1) @(negedge clk);
            eb  = (c <= 30);
            et  = (c >= 2 && c <= 9) || (c >= 16 && c <= 27) || (c >= 29 && c <= 30);
            ed  = 1'b0;
            ei  = (c <= 9) ? 3'd0 : (c <= 14) ? 3'd1 : (c <= 27) ? 3'd2 : 3'd0;
            edv = (c == 1) ? 32'd0 : (c <= 10) ? 32'd1000 : (c <= 15) ? 32'd0 :
                  (c <= 28) ? 32'd500 : (c <= 30) ? 32'd1000 : 32'd0;
            obs = {dif.busy, dif.tone_en, dif.done, dif.index, dif.divisor};
            exp = {eb, et, ed, ei, edv};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL loop_stop cyc%0d got %h expected %h", c, obs, exp);
            end
            dif.start      = (c == 5);
            dif.wr_en      = (c == 3);
            dif.wr_addr    = 3'd0;
            dif.wr_divisor = 32'd7777;
            dif.wr_dur_ms  = 16'd9;
            dif.stop       = (c == 30);
        end
        dif.start = 1'b0;
        dif.wr_en = 1'b0;
        dif.stop  = 1'b0;
    endtask

    task automatic test_dur_zero();
        write_entry(0, 123, 0);
        start_seq(1, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            eb  = (c <= 5);
            et  = (c >= 2 && c <= 5);
            ed  = (c == 6);
            ei  = 3'd0;
            edv = (c >= 2 && c <= 5) ? 32'd123 : 32'd0;
            obs = {dif.busy, dif.tone_en, dif.done, dif.index, dif.divisor};
            exp = {eb, et, ed, ei, edv};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL dur_zero cyc%0d got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_len_zero();
        start_seq(0, 1'b0);
        exp = '0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            obs = {dif.busy, dif.tone_en, dif.done, dif.index, dif.divisor};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL len_zero cyc%0d got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_len_clamp();
        for (int i = 0; i < 8; i++) write_entry(i, 100 + i, 1);
        start_seq(15, 1'b0);
        for (int c = 1; c <= 42; c++) begin
            if (c > 1) @(negedge clk);
            obs = {dif.busy, dif.tone_en, dif.done, dif.index, dif.divisor};
            if (c <= 40) begin
                int k, ph;
                k   = (c - 1) / 5;
                ph  = (c - 1) % 5;
                eb  = 1'b1;
                et  = (ph != 0);
                ed  = 1'b0;
                ei  = 3'(k);
                edv = (ph != 0) ? 32'(100 + k) : (k == 0) ? 32'd0 : 32'(99 + k);
            end else begin
                eb  = 1'b0;
                et  = 1'b0;
                ed  = (c == 41);
                ei  = 3'd0;
                edv = 32'd0;
                obs[34:32] = 3'd0;
            end
            exp = {eb, et, ed, ei, edv};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL len_clamp cyc%0d got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_start_stop_same();
        dif.start  = 1'b1;
        dif.stop   = 1'b1;
        dif.length = 4'd3;
        dif.loop   = 1'b0;
        @(negedge clk);
        dif.start = 1'b0;
        dif.stop  = 1'b0;
        exp = '0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            obs = {dif.busy, dif.tone_en, dif.done, dif.index, dif.divisor};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL start_stop_same cyc%0d got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_seq(3, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 7) begin
                int k, ph;
                k   = (c - 1) / 5;
                ph  = (c - 1) % 5;
                eb  = 1'b1;
                et  = (ph != 0);
                ed  = 1'b0;
                ei  = 3'(k);
                edv = (ph != 0) ? 32'(100 + k) : (k == 0) ? 32'd0 : 32'(99 + k);
            end else begin
                eb = 1'b0; et = 1'b0; ed = 1'b0; ei = 3'd0; edv = 32'd0;
            end
            obs = {dif.busy, dif.tone_en, dif.done, dif.index, dif.divisor};
            exp = {eb, et, ed, ei, edv};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_mid cyc%0d got %h expected %h", c, obs, exp);
            end
            reset = (c != 7);
        end
        reset = 1'b1;
        start_seq(3, 1'b0);
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) @(negedge clk);
            obs = {dif.busy, dif.tone_en, dif.done, dif.index, dif.divisor};
            if (c <= 15) begin
                int k, ph;
                k   = (c - 1) / 5;
                ph  = (c - 1) % 5;
                eb  = 1'b1;
                et  = (ph != 0);
                ed  = 1'b0;
                ei  = 3'(k);
                edv = (ph != 0) ? 32'(100 + k) : (k == 0) ? 32'd0 : 32'(99 + k);
            end else begin
                eb  = 1'b0;
                et  = 1'b0;
                ed  = (c == 16);
                ei  = 3'd0;
                edv = 32'd0;
                obs[34:32] = 3'd0;
            end
            exp = {eb, et, ed, ei, edv};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL replay_after_reset cyc%0d got %h expected %h", c, obs, exp);
            end
        end
    endtask

    initial begin
        reset          = 1'b0;
        dif.wr_en      = 1'b0;
        dif.wr_addr    = '0;
        dif.wr_divisor = '0;
        dif.wr_dur_ms  = '0;
        dif.length     = '0;
        dif.loop       = 1'b0;
        dif.start      = 1'b0;
        dif.stop       = 1'b0;
        test_reset();
        test_basic();
        test_loop_stop();
        test_dur_zero();
        test_len_zero();
        test_len_clamp();
        test_start_stop_same();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
